// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the MultDiv unit (multiplier now, divider later).
package multdiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} md_state_t;
endpackage

// File: rtl/and_array.sv
// Bitwise AND gate array used to gate the multiplicand with a replicated multiplier bit.
module and_array #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = a_i & b_i;
endmodule

// File: rtl/md_abs.sv
// Two's-complement magnitude and sign; the most negative value maps to its own bit pattern.
module md_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             sign_o
);
  assign sign_o = a_i[WIDTH-1];
  assign mag_o  = sign_o ? -a_i : a_i;
endmodule

// File: rtl/mult_shift_add.sv
// Sequential signed shift-add multiplier; MULT_EARLY_EXIT_EN ends RUN once the multiplier is exhausted.
//   state | meaning
//   IDLE  | waiting for ctrl_MULT
//   RUN   | one partial-product iteration per cycle
//   FIX   | sign correction, overflow evaluation
//   DONE  | data_resultRDY pulse
module mult_shift_add
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  md_state_t          state_q;
  logic [WIDTH-1:0]   mcand_q, mplier_q, result_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q, exc_q, rdy_q, busy_q;

  logic [WIDTH-1:0]   mag_a, mag_b, pp;
  logic               sign_a, sign_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_shr, acc_aligned, prod;
  logic               run_exit, ovf;

  md_abs #(.WIDTH(WIDTH)) u_abs_a (.a_i(data_operandA), .mag_o(mag_a), .sign_o(sign_a));
  md_abs #(.WIDTH(WIDTH)) u_abs_b (.a_i(data_operandB), .mag_o(mag_b), .sign_o(sign_b));

  and_array #(.WIDTH(WIDTH)) u_and (
    .a_i (mcand_q),
    .b_i ({WIDTH{mplier_q[0]}}),
    .y_o (pp)
  );

  assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, pp};
  assign acc_shr = {sum, acc_q[WIDTH-1:1]};

`ifdef MULT_EARLY_EXIT_EN
  // After cnt iterations the product sits (WIDTH - cnt) bits too high.
  logic [CNT_W-1:0] align_sh;
  assign align_sh    = CNT_W'(WIDTH) - cnt_q;
  assign acc_aligned = acc_q >> align_sh;
  assign run_exit    = (mplier_q == '0);
`else
  assign acc_aligned = acc_q;
  assign run_exit    = 1'b0;
`endif

  assign prod = neg_q ? -acc_aligned : acc_aligned;
  assign ovf  = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (ctrl_MULT) begin
        // A start in any state (including an abort of RUN/FIX) relaunches.
        mcand_q  <= mag_a;
        mplier_q <= mag_b;
        neg_q    <= sign_a ^ sign_b;
        acc_q    <= '0;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
        state_q  <= RUN;
      end else begin
        case (state_q)
          RUN: begin
            if (run_exit) begin
              state_q <= FIX;
            end else begin
              acc_q    <= acc_shr;
              mplier_q <= mplier_q >> 1;
              cnt_q    <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(WIDTH-1)) state_q <= FIX;
            end
          end
          FIX: begin
            result_q <= prod[WIDTH-1:0];
            exc_q    <= ovf;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_mult_shift_add.sv
// Directed-vector bench for mult_shift_add; expected latency follows MULT_EARLY_EXIT_EN.
module tb_mult_shift_add;
`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int FULL_LAT = 34;

  logic        clock, reset, ctrl_MULT;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic        data_exception, data_resultRDY, busy;

  int n_assert = 0;
  int n_fail   = 0;

  mult_shift_add dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat_early;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Drives a start pulse so that it is sampled on the next rising edge (edge T).
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1 ctrl_MULT = 1'b0;
  endtask

  // Returns at the negedge of the cycle where RDY is seen; cycle k = k-th negedge after edge T.
  task automatic wait_done(input string name, input int exp_lat,
                           input logic [31:0] exp_res, input logic exp_exc);
    int lat = 0;
    bit busy_gap = 0;
    for (int k = 1; k <= 80 && lat == 0; k++) begin
      @(negedge clock);
      if (data_resultRDY) lat = k;
      else if (!busy) busy_gap = 1;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy held until FIX"}, 64'(busy_gap), 64'd0);
    check({name, " busy low in DONE"}, 64'(busy), 64'd0);
    check({name, " result"}, 64'(data_result), 64'(exp_res));
    check({name, " exception"}, 64'(data_exception), 64'(exp_exc));
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'd3,          32'd5,          32'h0000000F, 1'b0, 6};
    vecs[1]  = '{32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0, 6};
    vecs[2]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1, 4};
    vecs[3]  = '{32'h80000000,   32'h00000001,   32'h80000000, 1'b0, 4};
    vecs[4]  = '{32'h00010000,   32'h00010000,   32'h00000000, 1'b1, 20};
    vecs[5]  = '{32'd0,          32'd12345,      32'h00000000, 1'b0, 17};
    vecs[6]  = '{32'd12345,      32'd0,          32'h00000000, 1'b0, 3};
    vecs[7]  = '{32'hFFFFFFFD,   32'hFFFFFFFC,   32'h0000000C, 1'b0, 6};
    vecs[8]  = '{32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE, 1'b1, 5};
    vecs[9]  = '{32'h40000000,   32'hFFFFFFFE,   32'h80000000, 1'b0, 5};
    vecs[10] = '{32'd100000,     32'hFFFE7960,   32'hABF41C00, 1'b1, 20};
    vecs[11] = '{32'd1,          32'h7FFFFFFF,   32'h7FFFFFFF, 1'b0, 35};

    reset = 1'b1; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset result", 64'(data_result), 64'd0);
    check("reset exception", 64'(data_exception), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      string nm;
      int    lat;
      nm = $sformatf("vec%0d", i);
      // |B| top bit 30 exits at cycle 34 under early exit as well
      lat = EARLY ? ((i == 11) ? 34 : vecs[i].lat_early) : FULL_LAT;
      start(vecs[i].a, vecs[i].b);
      wait_done(nm, lat, vecs[i].res, vecs[i].exc);
      @(negedge clock);
      check({nm, " rdy single pulse"}, 64'(data_resultRDY), 64'd0);
    end

    // Abort: second start at T+10 replaces the first; only one RDY.
    begin
      bit early_rdy = 0;
      start(32'd3, 32'd5);
      for (int k = 1; k <= 9; k++) begin
        @(negedge clock);
        if (data_resultRDY) early_rdy = 1;
      end
      start(32'd4, 32'd4);
      check("abort no rdy for first op", 64'(early_rdy), 64'd0);
      wait_done("abort", EARLY ? 6 : FULL_LAT, 32'd16, 1'b0);
    end

    // Reset mid-operation clears everything and suppresses RDY.
    begin
      bit seen = 0;
      bit busy_seen = 0;
      start(32'd3, 32'd5);
      repeat (19) @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("midreset result", 64'(data_result), 64'd0);
      check("midreset exception", 64'(data_exception), 64'd0);
      check("midreset busy", 64'(busy), 64'd0);
      for (int k = 0; k < 40; k++) begin
        @(negedge clock);
        if (data_resultRDY) seen = 1;
        if (busy) busy_seen = 1;
      end
      check("midreset no rdy", 64'(seen), 64'd0);
      check("midreset stays idle", 64'(busy_seen), 64'd0);
      start(32'd2, 32'd2);
      wait_done("after reset", EARLY ? 5 : FULL_LAT, 32'd4, 1'b0);
    end

    // Start during the DONE cycle: old RDY completes, new op launches on that edge.
    begin
      int k = 0;
      start(32'd3, 32'd5);
      while (!data_resultRDY && k < 80) begin
        @(negedge clock);
        k++;
      end
      check("done-start first latency", 64'(k), 64'(EARLY ? 6 : FULL_LAT));
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd6;
      data_operandB = 32'd7;
      @(posedge clock);
      #1 ctrl_MULT = 1'b0;
      @(negedge clock);
      check("done-start rdy dropped", 64'(data_resultRDY), 64'd0);
      check("done-start busy", 64'(busy), 64'd1);
      check("done-start result held", 64'(data_result), 64'd15);
      // cycle 1 of the new op has already been sampled
      wait_done("done-start second", EARLY ? 5 : FULL_LAT - 1, 32'd42, 1'b0);
    end

    // Outputs hold in IDLE.
    repeat (5) @(negedge clock);
    check("hold result", 64'(data_result), 64'd42);
    check("hold rdy low", 64'(data_resultRDY), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
